// File: rtl/pal_cfg_loader_if.sv
// Configuration bus between the frame source and the PAL configuration loader.
interface pal_cfg_loader_if #(
  parameter int CFG_W = 64
);
  logic             cfg_en;
  logic             cfg_shift;
  logic             cfg_sdi;
  logic [CFG_W-1:0] cfg_out;
  logic             cfg_sdo;
  logic             cfg_valid;
  logic             cfg_done;
  logic             cfg_err;
  logic             busy;

  modport master (
    output cfg_en, cfg_shift, cfg_sdi,
    input  cfg_out, cfg_sdo, cfg_valid, cfg_done, cfg_err, busy
  );

  modport slave (
    input  cfg_en, cfg_shift, cfg_sdi,
    output cfg_out, cfg_sdo, cfg_valid, cfg_done, cfg_err, busy
  );
endinterface

// File: rtl/pal_cfg_loader.sv
// Serial PAL configuration loader: shifts a frame into a shadow register and
// commits it to the active crosspoint register only when the frame is exactly CFG_W bits.
module pal_cfg_loader #(
  parameter int CFG_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  pal_cfg_loader_if.slave    bus
);
  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CFG_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [CFG_W-1:0] shadow_q;
  logic [CFG_W-1:0] active_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             valid_q;
  logic             done_q;
  logic             err_q;
  logic             busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cfg_en) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            if (bus.cfg_shift) begin
              shadow_q <= {shadow_q[CFG_W-2:0], bus.cfg_sdi};
              cnt_q    <= CNT_W'(1);
            end else begin
              cnt_q <= '0;
            end
          end
        end
        SHIFT: begin
          if (!bus.cfg_en) begin
            // Frame end: only an exact-length frame reaches the array.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (cnt_q == FULL && !ovf_q) begin
              active_q <= shadow_q;
              valid_q  <= 1'b1;
              done_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (bus.cfg_shift) begin
            shadow_q <= {shadow_q[CFG_W-2:0], bus.cfg_sdi};
            if (cnt_q == FULL) begin
              ovf_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cfg_out   = active_q;
  assign bus.cfg_sdo   = shadow_q[CFG_W-1];
  assign bus.cfg_valid = valid_q;
  assign bus.cfg_done  = done_q;
  assign bus.cfg_err   = err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader with CFG_W=8.
module tb_pal_cfg_loader;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] sh_model;

  pal_cfg_loader_if #(.CFG_W(W)) bus ();

  pal_cfg_loader #(.CFG_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then settle 1 time unit past it.
  task automatic step(input logic en, input logic sh, input logic sdi);
    bus.cfg_en    = en;
    bus.cfg_shift = sh;
    bus.cfg_sdi   = sdi;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] data, input int n);
    logic [15:0] d;
    d = data;
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, 1'b1, d[i]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.cfg_en    = 1'b0;
    bus.cfg_shift = 1'b0;
    bus.cfg_sdi   = 1'b0;
    rst = 1'b1;
    #12;
    check("rst_out",   64'(bus.cfg_out),   64'h00);
    check("rst_valid", 64'(bus.cfg_valid), 64'd0);
    check("rst_busy",  64'(bus.busy),      64'd0);
    check("rst_err",   64'(bus.cfg_err),   64'd0);
    check("rst_done",  64'(bus.cfg_done),  64'd0);
    check("rst_sdo",   64'(bus.cfg_sdo),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // Full frame 1,0,1,1,0,0,1,0
    step(1'b1, 1'b1, 1'b1);
    check("busy_rise", 64'(bus.busy), 64'd1);
    send_bits(16'b0110010, 7);
    check("pre_commit_out", 64'(bus.cfg_out), 64'h00);
    step(1'b0, 1'b1, 1'b1);
    check("full_out",   64'(bus.cfg_out),   64'hB2);
    check("full_valid", 64'(bus.cfg_valid), 64'd1);
    check("full_done",  64'(bus.cfg_done),  64'd1);
    check("full_err",   64'(bus.cfg_err),   64'd0);
    check("busy_fall",  64'(bus.busy),      64'd0);
    step(1'b0, 1'b0, 1'b0);
    check("done_pulse_end", 64'(bus.cfg_done), 64'd0);
    check("hold_out",       64'(bus.cfg_out),  64'hB2);

    // Short frame: 5 ones; shadow becomes 8'h5F so sdo = 0
    send_bits(16'b11111, 5);
    step(1'b0, 1'b0, 1'b0);
    check("short_err",  64'(bus.cfg_err),   64'd1);
    check("short_out",  64'(bus.cfg_out),   64'hB2);
    check("short_done", 64'(bus.cfg_done),  64'd0);
    check("short_sdo",  64'(bus.cfg_sdo),   64'd0);
    check("short_valid", 64'(bus.cfg_valid), 64'd1);
    step(1'b0, 1'b0, 1'b0);
    check("err_sticky", 64'(bus.cfg_err), 64'd1);

    // Overlong frame: 9 bits 0,1,1,1,1,1,1,1,1
    send_bits(16'b011111111, 9);
    step(1'b0, 1'b0, 1'b0);
    check("long_err",  64'(bus.cfg_err),  64'd1);
    check("long_out",  64'(bus.cfg_out),  64'hB2);
    check("long_done", 64'(bus.cfg_done), 64'd0);

    // All-ones frame clears err at frame start, then commits FF
    step(1'b1, 1'b1, 1'b1);
    check("err_clear", 64'(bus.cfg_err), 64'd0);
    send_bits(16'hFF, 7);
    step(1'b0, 1'b0, 1'b0);
    check("ones_out",  64'(bus.cfg_out),  64'hFF);
    check("ones_done", 64'(bus.cfg_done), 64'd1);
    check("ones_err",  64'(bus.cfg_err),  64'd0);

    // Gapped frame 8'h5A with a gap after every bit
    sh_model = 8'hFF;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] pat;
      pat = 8'h5A;
      step(1'b1, 1'b1, pat[i]);
      sh_model = {sh_model[6:0], pat[i]};
      check("gap_sdo_shift", 64'(bus.cfg_sdo), 64'(sh_model[7]));
      step(1'b1, 1'b0, ~pat[i]);
      check("gap_sdo_hold", 64'(bus.cfg_sdo), 64'(sh_model[7]));
      check("gap_busy", 64'(bus.busy), 64'd1);
    end
    step(1'b0, 1'b0, 1'b0);
    check("gap_out",  64'(bus.cfg_out),  64'h5A);
    check("gap_done", 64'(bus.cfg_done), 64'd1);

    // Back-to-back: load FF immediately after frame end, then mid-frame reset
    send_bits(16'hFF, 8);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_out", 64'(bus.cfg_out), 64'hFF);
    send_bits(16'b101, 3);
    rst = 1'b1;
    #2;
    check("mrst_out",   64'(bus.cfg_out),   64'h00);
    check("mrst_valid", 64'(bus.cfg_valid), 64'd0);
    check("mrst_busy",  64'(bus.busy),      64'd0);
    check("mrst_sdo",   64'(bus.cfg_sdo),   64'd0);
    rst = 1'b0;
    #1;
    send_bits(16'h3C, 8);
    step(1'b0, 1'b0, 1'b0);
    check("post_rst_out",   64'(bus.cfg_out),   64'h3C);
    check("post_rst_valid", 64'(bus.cfg_valid), 64'd1);
    check("post_rst_done",  64'(bus.cfg_done),  64'd1);
    check("post_rst_err",   64'(bus.cfg_err),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pal_cfg_loader.md
# pal_cfg_loader

Serial configuration loader for the PAL array. Sits directly upstream of the AND/OR plane crosspoints: it accepts a bit-serial configuration frame, assembles it in a shadow register, and on a valid frame end commits it atomically to the active configuration register. The active register drives every crosspoint `cfg_in`, so the array never sees a partially loaded pattern.

## Interface
- `CFG_W`, default 64: total crosspoint configuration bits (AND plane + OR plane); must be ≥ 2.
- `clk`  input  1  single system clock; all state updates on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `cfg_en`  input  1  frame gate; high for the duration of one configuration frame.
- `cfg_shift`  input  1  bit strobe; `cfg_sdi` is sampled on a cycle where `cfg_en` and `cfg_shift` are both 1.
- `cfg_sdi`  input  1  serial configuration data.
- `cfg_out`  output  CFG_W  active configuration, one bit per crosspoint (1 = connection enabled).
- `cfg_sdo`  output  1  serial chain out, equal to `shadow[CFG_W-1]`.
- `cfg_valid`  output  1  at least one frame has been committed since reset.
- `cfg_done`  output  1  one-cycle pulse on successful commit.
- `cfg_err`  output  1  last frame was rejected; sticky until the next frame starts.
- `busy`  output  1  state machine is in SHIFT.

## Operation
- Registers: `shadow[CFG_W-1:0]`, `active[CFG_W-1:0]` (drives `cfg_out`), bit counter `cnt` of width clog2(CFG_W+1), overflow flag `ovf`, state.
- States: IDLE, SHIFT.
- IDLE, `cfg_en`=0: hold everything.
- IDLE, `cfg_en`=1: go to SHIFT; clear `cnt`, `ovf`, `cfg_err`. If `cfg_shift`=1 on that same cycle, the bit is shifted in and `cnt` becomes 1.
- Shift operation: `shadow <= {shadow[CFG_W-2:0], cfg_sdi}`. The first bit of a frame ends at `cfg_out[CFG_W-1]` and the last bit at `cfg_out[0]`.
- SHIFT, `cfg_en`=1, `cfg_shift`=1:
  - `cnt < CFG_W`: shift and increment `cnt`.
  - `cnt == CFG_W`: shift, hold `cnt`, set `ovf`.
- SHIFT, `cfg_en`=0: frame end. `cfg_shift` is ignored on this cycle. Return to IDLE.
  - `cnt == CFG_W` and `ovf`=0: `active <= shadow`, `cfg_valid <= 1`, pulse `cfg_done`.
  - Otherwise (short or overlong frame): `cfg_err <= 1`. `active` and `cfg_valid` are unchanged.
- `shadow` is never cleared at frame start. Bits not yet overwritten remain visible on `cfg_sdo` for chain readback.
- `active` changes only at a successful commit or reset.

## Timing
- Reset values: `cfg_out`=0 (all crosspoints disconnected), `shadow`=0, `cfg_sdo`=0, `cfg_valid`=0, `cfg_done`=0, `cfg_err`=0, `busy`=0, state IDLE, `cnt`=0.
- `busy` rises the cycle after `cfg_en` is first sampled high. It falls the cycle after `cfg_en` is sampled low.
- Commit latency: `cfg_out`, `cfg_done`, and `cfg_valid` update on the edge that samples `cfg_en`=0. They are visible in the following cycle. `cfg_done` is high for exactly that one cycle.
- `cfg_sdo` reflects the shadow MSB one cycle after each shift.
- Minimum frame: CFG_W consecutive strobed cycles, then one cycle with `cfg_en` low. Back-to-back frames are allowed: `cfg_en` may rise again on the cycle immediately after the frame-end cycle.
- A gap cycle (`cfg_en`=1, `cfg_shift`=0) holds all state.
- `rst` asserted mid-frame: all registers take reset values immediately (asynchronous). The partial frame is discarded, and `cfg_out` returns to 0.

## Test plan
- Run with CFG_W=8.
- Reset check: assert `rst` -> `cfg_out`=8'h00, `cfg_valid`=0, `busy`=0, `cfg_err`=0, `cfg_done`=0.
- Full frame: shift 1,0,1,1,0,0,1,0 on 8 consecutive cycles, then drop `cfg_en` -> `cfg_out`=8'hB2, `cfg_valid`=1, `cfg_done` high for 1 cycle, `cfg_err`=0.
- Short frame after a valid load: shift 5 bits of 1 -> `cfg_err`=1, `cfg_out` stays 8'hB2, `cfg_done` stays 0.
- Overlong frame: shift 9 bits 0,1,1,1,1,1,1,1,1 -> `cfg_err`=1, `cfg_out` unchanged. Next correct frame of all 1s clears `cfg_err` at frame start and commits 8'hFF.
- Gapped frame: 8 bits 8'h5A delivered with idle strobe cycles interleaved -> `cfg_out`=8'h5A. `cfg_sdo` sequence matches shadow MSB after each shift.
- Mid-frame reset: load 8'hFF, start a new frame, pulse `rst` after 3 bits -> `cfg_out`=8'h00, `cfg_valid`=0 immediately. A following full 8'h3C frame commits normally.
